// File: rtl/alu_divider.sv
// Iterative restoring divider for the EX stage: one quotient bit per clock,
// signed (div) or unsigned (divu), results held for write-back into HI/LO.
module alu_divider #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   signed_op,
    input  logic [WORD_LENGTH-1:0] dividend,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] quotient,
    output logic [WORD_LENGTH-1:0] remainder,
    output logic                   div_by_zero
);

    localparam int CW = $clog2(WORD_LENGTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CW-1:0]          count;
    logic [WORD_LENGTH-1:0] rem;
    logic [WORD_LENGTH-1:0] quo;
    logic [WORD_LENGTH-1:0] dvs;
    logic                   q_neg;
    logic                   r_neg;
    logic                   dz;

    logic                   dvd_neg;
    logic                   dvs_neg;
    logic [WORD_LENGTH-1:0] dvd_mag;
    logic [WORD_LENGTH-1:0] dvs_mag;
    logic [WORD_LENGTH:0]   rem_shift;
    logic                   trial_ok;

    // The magnitude of the most-negative value is 2^(W-1), which still fits
    // in W unsigned bits, so plain two's-complement negation is enough.
    always_comb begin
        dvd_neg   = signed_op & dividend[WORD_LENGTH-1];
        dvs_neg   = signed_op & divisor[WORD_LENGTH-1];
        dvd_mag   = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag   = dvs_neg ? (~divisor + 1'b1) : divisor;
        rem_shift = {rem, quo[WORD_LENGTH-1]};
        trial_ok  = rem_shift >= {1'b0, dvs};
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN: begin
                busy = 1'b1;
                if (count == '0) next_state = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem   <= '0;
                        quo   <= dvd_mag;
                        dvs   <= dvs_mag;
                        q_neg <= dvd_neg ^ dvs_neg;
                        r_neg <= dvd_neg;
                        dz    <= (divisor == '0);
                        count <= CW'(WORD_LENGTH);
                    end
                end
                RUN: begin
                    if (count != '0) begin
                        // The true difference is below 2^W, so W-bit wrap is exact.
                        rem   <= trial_ok ? (rem_shift[WORD_LENGTH-1:0] - dvs)
                                          : rem_shift[WORD_LENGTH-1:0];
                        quo   <= {quo[WORD_LENGTH-2:0], trial_ok};
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    // A zero divisor leaves |dividend| in rem, so only the quotient is forced.
                    if (dz)
                        quotient <= '1;
                    else
                        quotient <= q_neg ? (~quo + 1'b1) : quo;
                    remainder   <= r_neg ? (~rem + 1'b1) : rem;
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule
